// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: rasterizer beat stream -> linear framebuffer writes.
// Optional frame-start clear is compiled in with FB_PIXEL_WRITER_CLEAR_EN.
module fb_pixel_writer #(
    parameter int FB_WIDTH = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int FIFO_DEPTH = 8,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [7:0]        in_color,
    input  logic [10:0]       in_x,
    input  logic [10:0]       in_y,
    input  logic              in_draw,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_end_in,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [7:0]        fb_wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       clipped_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DRAW,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic        draw;
        logic [10:0] y;
        logic [10:0] x;
        logic [7:0]  color;
    } beat_t;

    state_t             state;
    beat_t              mem [FIFO_DEPTH];
    beat_t              in_beat;
    beat_t              head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;
    logic               stage_valid;
    logic               fe_q;
    logic               fe_rise;
    logic               head_oob;
    logic [ADDR_W-1:0]  head_addr;

`ifdef FB_PIXEL_WRITER_CLEAR_EN
    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    logic [ADDR_W:0]    clr_cnt;
    logic               fe_pending;
`endif

    // Handshake, FIFO control and address-compute decode of the FIFO head.
    always_comb begin
        in_ready  = (state == DRAW) && (fifo_count != CNT_W'(FIFO_DEPTH));
        busy      = (state != IDLE);
        push      = in_valid && in_ready;
        pop       = (fifo_count != '0);
        in_beat   = '{draw: in_draw, y: in_y, x: in_x, color: in_color};
        head      = mem[rd_ptr];
        fe_rise   = frame_end_in && !fe_q;
        head_oob  = (int'(head.x) >= FB_WIDTH) || (int'(head.y) >= FB_HEIGHT);
        head_addr = ADDR_W'(head.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(head.x);
    end

    // FIFO storage; contents need no reset since the pointers guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_beat;
        end
    end

    // Frame FSM, FIFO pointers, address stage and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            stage_valid   <= 1'b0;
            fe_q          <= 1'b0;
            fb_wr_en      <= 1'b0;
            fb_wr_addr    <= '0;
            fb_wr_data    <= '0;
            done          <= 1'b0;
            clipped_count <= '0;
`ifdef FB_PIXEL_WRITER_CLEAR_EN
            clr_cnt       <= '0;
            fe_pending    <= 1'b0;
`endif
        end else begin
            fe_q        <= frame_end_in;
            fb_wr_en    <= 1'b0;
            done        <= 1'b0;
            stage_valid <= pop;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            if (!push && pop) fifo_count <= fifo_count - 1'b1;

            if (pop && head.draw) begin
                if (head_oob) begin
                    if (clipped_count != 16'hFFFF)
                        clipped_count <= clipped_count + 16'd1;
                end else begin
                    fb_wr_en   <= 1'b1;
                    fb_wr_addr <= head_addr;
                    fb_wr_data <= head.color;
                end
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        clipped_count <= '0;
`ifdef FB_PIXEL_WRITER_CLEAR_EN
                        // First clear write issues here so writes start at S+1.
                        state      <= CLEAR;
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= '0;
                        fb_wr_data <= CLEAR_COLOR;
                        clr_cnt    <= (ADDR_W+1)'(1);
                        fe_pending <= 1'b0;
`else
                        state <= DRAW;
`endif
                    end
                end
`ifdef FB_PIXEL_WRITER_CLEAR_EN
                CLEAR: begin
                    if (fe_rise) fe_pending <= 1'b1;
                    if (clr_cnt == (ADDR_W+1)'(NPIX)) begin
                        state      <= (fe_pending || fe_rise) ? FLUSH : DRAW;
                        fe_pending <= 1'b0;
                    end else begin
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= clr_cnt[ADDR_W-1:0];
                        fb_wr_data <= CLEAR_COLOR;
                        clr_cnt    <= clr_cnt + 1'b1;
                    end
                end
`endif
                DRAW: begin
                    if (fe_rise) state <= FLUSH;
                end
                FLUSH: begin
                    if (fifo_count == '0 && !stage_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer (8x4 framebuffer, 4-deep FIFO).
// Clear-related scenarios run when FB_PIXEL_WRITER_CLEAR_EN is defined.
module tb_fb_pixel_writer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [7:0]    in_color = '0;
    logic [10:0]   in_x = '0;
    logic [10:0]   in_y = '0;
    logic          in_draw = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          frame_end_in = 1'b0;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [7:0]    fb_wr_data;
    logic          busy;
    logic          done;
    logic [15:0]   clipped_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cnt = 0;
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];

    fb_pixel_writer #(
        .FB_WIDTH(W),
        .FB_HEIGHT(H),
        .ADDR_W(AW),
        .FIFO_DEPTH(4),
        .CLEAR_COLOR(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .in_color(in_color),
        .in_x(in_x),
        .in_y(in_y),
        .in_draw(in_draw),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .frame_end_in(frame_end_in),
        .fb_wr_en(fb_wr_en),
        .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data),
        .busy(busy),
        .done(done),
        .clipped_count(clipped_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_wr_en) begin
            wq_addr.push_back(int'(fb_wr_addr));
            wq_data.push_back(int'(fb_wr_data));
            wq_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_valid && in_ready) acc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wq();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic send_beat(input int x, input int y, input int c,
                             input bit d, output int t);
        int n;
        in_x = 11'(x);
        in_y = 11'(y);
        in_color = 8'(c);
        in_draw = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready=%0b required 1", in_ready);
        end
        t = cyc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        int n;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_frame_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (fb_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en: got %0b required 0", fb_wr_en);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b required 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %0b required 0", done);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 0", in_ready);
        end
        checks++;
        if (clipped_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_clipped: got %0d required 0", clipped_count);
        end
        checks++;
        if (fb_wr_addr !== '0 || fb_wr_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_wr_bus: addr=%0d data=%0h required 0/0",
                     fb_wr_addr, fb_wr_data);
        end
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b in_ready=%0b required 0/0",
                     busy, in_ready);
        end
    endtask

`ifdef FB_PIXEL_WRITER_CLEAR_EN
    task automatic test_clear();
        int s;
        int hi;
        clear_wq();
        frame_start = 1'b1;
        s = cyc;
        step();
        frame_start = 1'b0;
        hi = 0;
        for (int k = 1; k <= N; k++) begin
            if (in_ready !== 1'b0) hi++;
            step();
        end
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL clear_ready_low: ready high in %0d cycles required 0", hi);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready_rise: in_ready=%0b at S+N+1 required 1", in_ready);
        end
        checks++;
        if (wq_addr.size() !== N) begin
            errors++;
            $display("FAIL clear_count: got %0d writes required %0d", wq_addr.size(), N);
        end
        for (int i = 0; i < N && i < wq_addr.size(); i++) begin
            checks++;
            if (wq_addr[i] !== i || wq_data[i] !== 0 || wq_cyc[i] !== s + 1 + i) begin
                errors++;
                $display("FAIL clear_write_%0d: addr=%0d data=%0h cyc=%0d required %0d/0/%0d",
                         i, wq_addr[i], wq_data[i], wq_cyc[i], i, s + 1 + i);
            end
        end
    endtask
`endif

    task automatic test_single_pixel();
        int t;
        clear_wq();
        send_beat(3, 2, 8'hA5, 1'b1, t);
        repeat (4) step();
        checks++;
        if (wq_addr.size() !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes required 1", wq_addr.size());
        end
        if (wq_addr.size() > 0) begin
            checks++;
            if (wq_addr[0] !== 19) begin
                errors++;
                $display("FAIL single_addr: got %0d required 19", wq_addr[0]);
            end
            checks++;
            if (wq_data[0] !== 8'hA5) begin
                errors++;
                $display("FAIL single_data: got %0h required a5", wq_data[0]);
            end
            checks++;
            if (wq_cyc[0] !== t + 2) begin
                errors++;
                $display("FAIL single_latency: write cyc %0d required %0d", wq_cyc[0], t + 2);
            end
        end
    endtask

    task automatic test_clip();
        int t;
        clear_wq();
        send_beat(8, 0, 8'h11, 1'b1, t);
        repeat (3) step();
        checks++;
        if (wq_addr.size() !== 0 || clipped_count !== 16'd1) begin
            errors++;
            $display("FAIL clip_x: writes=%0d clipped=%0d required 0/1",
                     wq_addr.size(), clipped_count);
        end
        send_beat(1, 1, 8'h22, 1'b0, t);
        repeat (3) step();
        checks++;
        if (wq_addr.size() !== 0 || clipped_count !== 16'd1) begin
            errors++;
            $display("FAIL discard: writes=%0d clipped=%0d required 0/1",
                     wq_addr.size(), clipped_count);
        end
        send_beat(7, 4, 8'h33, 1'b1, t);
        repeat (3) step();
        checks++;
        if (wq_addr.size() !== 0 || clipped_count !== 16'd2) begin
            errors++;
            $display("FAIL clip_y: writes=%0d clipped=%0d required 0/2",
                     wq_addr.size(), clipped_count);
        end
        send_beat(7, 3, 8'h44, 1'b1, t);
        repeat (3) step();
        checks++;
        if (wq_addr.size() !== 1) begin
            errors++;
            $display("FAIL corner_count: got %0d writes required 1", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 31 || wq_data[0] !== 8'h44) begin
                errors++;
                $display("FAIL corner_write: addr=%0d data=%0h required 31/44",
                         wq_addr[0], wq_data[0]);
            end
        end
        checks++;
        if (clipped_count !== 16'd2) begin
            errors++;
            $display("FAIL corner_clipped: got %0d required 2", clipped_count);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int t0;
        clear_wq();
        t0 = 0;
        for (int i = 0; i < 10; i++) begin
            send_beat(i % W, i / W, 8'h10 + i, 1'b1, t);
            if (i == 0) t0 = t;
        end
        repeat (4) step();
        checks++;
        if (wq_addr.size() !== 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes required 10", wq_addr.size());
        end
        for (int i = 0; i < 10 && i < wq_addr.size(); i++) begin
            checks++;
            if (wq_addr[i] !== i || wq_data[i] !== 8'h10 + i || wq_cyc[i] !== t0 + 2 + i) begin
                errors++;
                $display("FAIL b2b_write_%0d: addr=%0d data=%0h cyc=%0d required %0d/%0h/%0d",
                         i, wq_addr[i], wq_data[i], wq_cyc[i], i, 8'h10 + i, t0 + 2 + i);
            end
        end
    endtask

    task automatic test_frame_end_burst();
        int t;
        int d0;
        int hi;
        clear_wq();
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) frame_end_in = 1'b1;
            send_beat(i, 1, 8'hC0 + i, 1'b1, t);
        end
        in_x = 11'd4;
        in_y = 11'd1;
        in_color = 8'hC4;
        in_draw = 1'b1;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%0b after frame end required 0", in_ready);
        end
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (in_ready !== 1'b0) hi++;
        end
        in_valid = 1'b0;
        frame_end_in = 1'b0;
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL flush_ready_hold: ready high in %0d cycles required 0", hi);
        end
        checks++;
        if (wq_addr.size() !== 4) begin
            errors++;
            $display("FAIL flush_count: got %0d writes required 4", wq_addr.size());
        end
        for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
            checks++;
            if (wq_addr[i] !== 8 + i || wq_data[i] !== 8'hC0 + i) begin
                errors++;
                $display("FAIL flush_write_%0d: addr=%0d data=%0h required %0d/%0h",
                         i, wq_addr[i], wq_data[i], 8 + i, 8'hC0 + i);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL flush_done: %0d pulses required 1", done_cnt - d0);
        end
        if (wq_cyc.size() > 0) begin
            checks++;
            if (done_cyc <= wq_cyc[wq_cyc.size() - 1]) begin
                errors++;
                $display("FAIL flush_done_order: done cyc %0d required after %0d",
                         done_cyc, wq_cyc[wq_cyc.size() - 1]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%0b required 0", busy);
        end
    endtask

`ifdef FB_PIXEL_WRITER_CLEAR_EN
    task automatic test_frame_end_in_clear();
        int s;
        int d0;
        int a0;
        int n;
        int bad;
        clear_wq();
        d0 = done_cnt;
        a0 = acc_cnt;
        in_x = 11'd2;
        in_y = 11'd2;
        in_color = 8'h5A;
        in_draw = 1'b1;
        in_valid = 1'b1;
        frame_start = 1'b1;
        s = cyc;
        step();
        frame_start = 1'b0;
        while (cyc < s + 6) step();
        frame_end_in = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 80) begin
            step();
            n++;
        end
        repeat (3) step();
        in_valid = 1'b0;
        frame_end_in = 1'b0;
        checks++;
        if (wq_addr.size() !== N) begin
            errors++;
            $display("FAIL fe_clear_count: got %0d writes required %0d", wq_addr.size(), N);
        end
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] !== i || wq_data[i] !== 0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL fe_clear_writes: %0d bad writes required 0", bad);
        end
        checks++;
        if (acc_cnt - a0 !== 0) begin
            errors++;
            $display("FAIL fe_clear_accept: %0d beats accepted required 0", acc_cnt - a0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL fe_clear_done: %0d pulses required 1", done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fe_clear_idle: busy=%0b required 0", busy);
        end
    endtask
`endif

    task automatic test_reset_mid_draw();
        int t;
        int t0;
        int d0;
        int late;
        start_frame();
        clear_wq();
        d0 = done_cnt;
        t0 = 0;
        for (int i = 0; i < 3; i++) begin
            send_beat(i, 3, 8'hE0 + i, 1'b1, t);
            if (i == 0) t0 = t;
        end
        reset = 1'b1;
        step();
        checks++;
        if (fb_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wr_en: got %0b required 0", fb_wr_en);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_status: busy=%0b in_ready=%0b done=%0b required 0/0/0",
                     busy, in_ready, done);
        end
        reset = 1'b0;
        repeat (4) step();
        late = 0;
        for (int i = 0; i < wq_cyc.size(); i++)
            if (wq_cyc[i] >= t0 + 4) late++;
        checks++;
        if (late !== 0 || wq_addr.size() !== 2) begin
            errors++;
            $display("FAIL rst_mid_writes: %0d late of %0d writes required 0 of 2",
                     late, wq_addr.size());
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%0b in_ready=%0b dones=%0d required 0/0/0",
                     busy, in_ready, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
`ifdef FB_PIXEL_WRITER_CLEAR_EN
        test_clear();
`else
        start_frame();
`endif
        test_single_pixel();
        test_clip();
        test_back_to_back();
        test_frame_end_burst();
`ifdef FB_PIXEL_WRITER_CLEAR_EN
        test_frame_end_in_clear();
`endif
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
